// File: rtl/bru_issue_queue.sv
// In-order issue queue for the branch unit; snoops two writeback ports for operand wakeup.
// Optional: define BRU_WB_BYPASS_EN to let a same-cycle writeback make the head issuable.
module bru_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int ST_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [11:0]            enq_op,
  input  logic [ST_W-1:0]        enq_status,
  input  logic [TAG_W-1:0]       enq_src1_tag,
  input  logic [TAG_W-1:0]       enq_src2_tag,
  input  logic                   enq_src1_rdy,
  input  logic                   enq_src2_rdy,
  input  logic [31:0]            enq_src1_val,
  input  logic [31:0]            enq_src2_val,
  input  logic                   wb0_valid,
  input  logic [TAG_W-1:0]       wb0_tag,
  input  logic [31:0]            wb0_data,
  input  logic                   wb1_valid,
  input  logic [TAG_W-1:0]       wb1_tag,
  input  logic [31:0]            wb1_data,
  input  logic                   flush,
  output logic                   issue_valid,
  output logic [11:0]            issue_op,
  output logic [ST_W-1:0]        issue_status,
  output logic [31:0]            issue_rdata1,
  output logic [31:0]            issue_rdata2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [11:0]      op_q   [DEPTH];
  logic [ST_W-1:0]  st_q   [DEPTH];
  logic [TAG_W-1:0] tag1_q [DEPTH];
  logic [TAG_W-1:0] tag2_q [DEPTH];
  logic [31:0]      val1_q [DEPTH];
  logic [31:0]      val2_q [DEPTH];
  logic [DEPTH-1:0] rdy1_q, rdy2_q;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q;

  logic [PTR_W-1:0] off [DEPTH];
  logic [DEPTH-1:0] live;
  logic             do_enq, do_issue;
  logic             e1_hit0, e1_hit1, e2_hit0, e2_hit1;
  logic             h1_ok, h2_ok;
  logic [31:0]      h1_val, h2_val;

  assign count     = count_q;
  assign enq_ready = (count_q != FULL);
  assign do_enq    = enq_valid & enq_ready & ~flush;

  assign e1_hit0 = wb0_valid && (wb0_tag == enq_src1_tag);
  assign e1_hit1 = wb1_valid && (wb1_tag == enq_src1_tag);
  assign e2_hit0 = wb0_valid && (wb0_tag == enq_src2_tag);
  assign e2_hit1 = wb1_valid && (wb1_tag == enq_src2_tag);

  // An entry is live when its distance from head (mod DEPTH) is below the occupancy.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off[i]  = PTR_W'(i) - head;
      live[i] = ({1'b0, off[i]} < count_q);
    end
  end

`ifdef BRU_WB_BYPASS_EN
  logic h1_w0, h1_w1, h2_w0, h2_w1;
  assign h1_w0  = wb0_valid && (wb0_tag == tag1_q[head]);
  assign h1_w1  = wb1_valid && (wb1_tag == tag1_q[head]);
  assign h2_w0  = wb0_valid && (wb0_tag == tag2_q[head]);
  assign h2_w1  = wb1_valid && (wb1_tag == tag2_q[head]);
  assign h1_ok  = rdy1_q[head] | h1_w0 | h1_w1;
  assign h2_ok  = rdy2_q[head] | h2_w0 | h2_w1;
  assign h1_val = rdy1_q[head] ? val1_q[head] : (h1_w0 ? wb0_data : wb1_data);
  assign h2_val = rdy2_q[head] ? val2_q[head] : (h2_w0 ? wb0_data : wb1_data);
`else
  assign h1_ok  = rdy1_q[head];
  assign h2_ok  = rdy2_q[head];
  assign h1_val = val1_q[head];
  assign h2_val = val2_q[head];
`endif

  assign do_issue     = ~rst & (count_q != '0) & h1_ok & h2_ok & ~flush;
  assign issue_valid  = do_issue;
  assign issue_op     = do_issue ? op_q[head] : '0;
  assign issue_status = do_issue ? st_q[head] : '0;
  assign issue_rdata1 = do_issue ? h1_val : '0;
  assign issue_rdata2 = do_issue ? h2_val : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live[i] && !rdy1_q[i]) begin
          if (wb0_valid && (wb0_tag == tag1_q[i])) begin
            rdy1_q[i] <= 1'b1;
            val1_q[i] <= wb0_data;
          end else if (wb1_valid && (wb1_tag == tag1_q[i])) begin
            rdy1_q[i] <= 1'b1;
            val1_q[i] <= wb1_data;
          end
        end
        if (live[i] && !rdy2_q[i]) begin
          if (wb0_valid && (wb0_tag == tag2_q[i])) begin
            rdy2_q[i] <= 1'b1;
            val2_q[i] <= wb0_data;
          end else if (wb1_valid && (wb1_tag == tag2_q[i])) begin
            rdy2_q[i] <= 1'b1;
            val2_q[i] <= wb1_data;
          end
        end
      end
      // Tail slot is never live while enqueue is allowed, so this cannot clash with wakeup.
      if (do_enq) begin
        op_q[tail]   <= enq_op;
        st_q[tail]   <= enq_status;
        tag1_q[tail] <= enq_src1_tag;
        tag2_q[tail] <= enq_src2_tag;
        rdy1_q[tail] <= enq_src1_rdy | e1_hit0 | e1_hit1;
        rdy2_q[tail] <= enq_src2_rdy | e2_hit0 | e2_hit1;
        val1_q[tail] <= enq_src1_rdy ? enq_src1_val : (e1_hit0 ? wb0_data : wb1_data);
        val2_q[tail] <= enq_src2_rdy ? enq_src2_val : (e2_hit0 ? wb0_data : wb1_data);
        tail         <= tail + 1'b1;
      end
      if (do_issue)
        head <= head + 1'b1;
      case ({do_enq, do_issue})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bru_issue_queue.sv
// Scoreboard bench for bru_issue_queue: expected issues are queued at enqueue, a monitor pops on issue_valid.
module tb_bru_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int ST_W  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             enq_valid, enq_ready;
  logic [11:0]      enq_op;
  logic [ST_W-1:0]  enq_status;
  logic [TAG_W-1:0] enq_src1_tag, enq_src2_tag;
  logic             enq_src1_rdy, enq_src2_rdy;
  logic [31:0]      enq_src1_val, enq_src2_val;
  logic             wb0_valid, wb1_valid;
  logic [TAG_W-1:0] wb0_tag, wb1_tag;
  logic [31:0]      wb0_data, wb1_data;
  logic             flush;
  logic             issue_valid;
  logic [11:0]      issue_op;
  logic [ST_W-1:0]  issue_status;
  logic [31:0]      issue_rdata1, issue_rdata2;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  bru_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ST_W(ST_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op), .enq_status(enq_status),
    .enq_src1_tag(enq_src1_tag), .enq_src2_tag(enq_src2_tag),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_src1_val(enq_src1_val), .enq_src2_val(enq_src2_val),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_status(issue_status),
    .issue_rdata1(issue_rdata1), .issue_rdata2(issue_rdata2), .count(count)
  );

  typedef struct packed {
    logic [11:0] op;
    logic [63:0] st;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wake_d [4] = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};

  function automatic logic [63:0] st_of(input logic [11:0] op);
    return {20'hB4A00, 32'h1234_5678, op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    enq_valid = 0; enq_op = '0; enq_status = '0;
    enq_src1_tag = '0; enq_src2_tag = '0; enq_src1_rdy = 0; enq_src2_rdy = 0;
    enq_src1_val = '0; enq_src2_val = '0;
    wb0_valid = 0; wb0_tag = '0; wb0_data = '0;
    wb1_valid = 0; wb1_tag = '0; wb1_data = '0;
    flush = 0;
  endtask

  task automatic set_enq(input logic [11:0] op,
                         input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                         input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    enq_valid = 1; enq_op = op; enq_status = st_of(op);
    enq_src1_tag = t1; enq_src1_rdy = r1; enq_src1_val = v1;
    enq_src2_tag = t2; enq_src2_rdy = r2; enq_src2_val = v2;
  endtask

  task automatic push_exp(input logic [11:0] op, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.op = op; e.st = st_of(op); e.r1 = r1; e.r2 = r2;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int k = 0;
    while (count != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(count), 64'd0);
  endtask

  // Monitor: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got op %0h expected no issue (t=%0t)", issue_op, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_op", 64'(issue_op), 64'(mon_e.op));
        chk("issue_status", issue_status, mon_e.st);
        chk("issue_rdata1", 64'(issue_rdata1), 64'(mon_e.r1));
        chk("issue_rdata2", 64'(issue_rdata2), 64'(mon_e.r2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear();
    rst = 1;
    tick(); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    tick(); tick();
    rst = 0; #1;
    chk("idle_issue_valid", 64'(issue_valid), 64'd0);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_enq_ready", 64'(enq_ready), 64'd1);
    chk("idle_issue_op", 64'(issue_op), 64'd0);
    chk("idle_issue_status", issue_status, 64'd0);
    chk("idle_rdata1", 64'(issue_rdata1), 64'd0);
    chk("idle_rdata2", 64'(issue_rdata2), 64'd0);

    // beq with both operands ready: issue one cycle after enqueue.
    tick(); clear();
    set_enq(12'h800, 6'd0, 1, 32'h10, 6'd0, 1, 32'h10);
    push_exp(12'h800, 32'h10, 32'h10);
    #1;
    chk("beq_c0_issue_valid", 64'(issue_valid), 64'd0);
    tick(); clear(); #1;
    chk("beq_c1_issue_valid", 64'(issue_valid), 64'd1);
    chk("beq_c1_count", 64'(count), 64'd1);
    tick(); #1;
    chk("beq_c2_count", 64'(count), 64'd0);

    // bne waits on tag 5; younger ready jal must not bypass it.
    tick(); clear();
    set_enq(12'h400, 6'd5, 0, 32'h0, 6'd0, 1, 32'h22);
    push_exp(12'h400, 32'hABCD, 32'h22);
    tick(); clear();
    set_enq(12'h001, 6'd0, 1, 32'h100, 6'd0, 1, 32'h200);
    push_exp(12'h001, 32'h100, 32'h200);
    #1;
    chk("bne_c1_hold", 64'(issue_valid), 64'd0);
    tick(); clear(); #1;
    chk("bne_c2_hold", 64'(issue_valid), 64'd0);
    chk("bne_c2_count", 64'(count), 64'd2);
    tick(); clear();
    wb1_valid = 1; wb1_tag = 6'd5; wb1_data = 32'hABCD;
    #1;
`ifdef BRU_WB_BYPASS_EN
    chk("bne_c3_bypass_issue", 64'(issue_valid), 64'd1);
`else
    chk("bne_c3_hold", 64'(issue_valid), 64'd0);
`endif
    tick(); clear(); #1;
`ifndef BRU_WB_BYPASS_EN
    chk("bne_c4_issue_valid", 64'(issue_valid), 64'd1);
    chk("bne_c4_rdata1", 64'(issue_rdata1), 64'hABCD);
    tick(); #1;
    chk("jal_c5_issue_op", 64'(issue_op), 64'h001);
`endif
    wait_empty(10, "bne_jal_drain");

    // Fill to DEPTH, reject a fifth, then wake and drain across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      tick(); clear();
      set_enq(12'h002 << i, 6'(10 + i), 0, 32'h0, 6'd0, 1, 32'(i));
      push_exp(12'h002 << i, wake_d[i], 32'(i));
      #1;
      chk("fill_count", 64'(count), 64'(i));
    end
    tick(); clear();
    set_enq(12'h020, 6'd0, 1, 32'h999, 6'd0, 1, 32'h999);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    tick(); clear();
    wb0_valid = 1; wb0_tag = 6'd10; wb0_data = 32'hA0;
    #1;
    chk("fifth_dropped_count", 64'(count), 64'd4);
    tick(); clear(); #1;
`ifndef BRU_WB_BYPASS_EN
    chk("full_head_issue", 64'(issue_valid), 64'd1);
    chk("full_still_not_ready", 64'(enq_ready), 64'd0);
`endif
    tick(); clear();
    wb0_valid = 1; wb0_tag = 6'd11; wb0_data = 32'hB1;
    wb1_valid = 1; wb1_tag = 6'd12; wb1_data = 32'hC2;
    set_enq(12'h040, 6'd0, 1, 32'h501, 6'd0, 1, 32'h502);
    push_exp(12'h040, 32'h501, 32'h502);
    #1;
`ifndef BRU_WB_BYPASS_EN
    chk("room_count", 64'(count), 64'd3);
    chk("room_enq_ready", 64'(enq_ready), 64'd1);
`endif
    tick(); clear();
    wb0_valid = 1; wb0_tag = 6'd13; wb0_data = 32'hD3;
    tick(); clear();
    set_enq(12'h080, 6'd0, 1, 32'h601, 6'd0, 1, 32'h602);
    push_exp(12'h080, 32'h601, 32'h602);
    tick(); clear();
    set_enq(12'h100, 6'd0, 1, 32'h701, 6'd0, 1, 32'h702);
    push_exp(12'h100, 32'h701, 32'h702);
    #1;
`ifndef BRU_WB_BYPASS_EN
    chk("enq_issue_count_hold", 64'(count), 64'd3);
`endif
    tick(); clear();
    wait_empty(30, "wrap_drain");

    // Flush with a ready head and a concurrent enqueue: nothing issues afterwards.
    tick(); clear();
    set_enq(12'h200, 6'd30, 0, 32'h0, 6'd0, 1, 32'h1);
    tick(); clear();
    set_enq(12'h400, 6'd0, 1, 32'h2, 6'd0, 1, 32'h2);
    tick(); clear();
    set_enq(12'h800, 6'd0, 1, 32'h3, 6'd0, 1, 32'h3);
    tick(); clear();
`ifndef BRU_WB_BYPASS_EN
    wb0_valid = 1; wb0_tag = 6'd30; wb0_data = 32'h3;
`endif
    #1;
    chk("preflush_count", 64'(count), 64'd3);
    tick(); clear();
`ifdef BRU_WB_BYPASS_EN
    wb0_valid = 1; wb0_tag = 6'd30; wb0_data = 32'h3;
`endif
    flush = 1;
    set_enq(12'h001, 6'd0, 1, 32'h4, 6'd0, 1, 32'h4);
    #1;
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    tick(); clear(); #1;
    chk("postflush_count", 64'(count), 64'd0);
    chk("postflush_issue_valid", 64'(issue_valid), 64'd0);
    repeat (4) tick();

    // Same tag on both wb ports: wb0 data wins for queued and enqueuing sources.
    tick(); clear();
    set_enq(12'h010, 6'd7, 0, 32'h0, 6'd0, 1, 32'h55);
    push_exp(12'h010, 32'h1, 32'h55);
    tick(); clear();
    set_enq(12'h008, 6'd9, 1, 32'h66, 6'd7, 0, 32'h0);
    push_exp(12'h008, 32'h66, 32'h1);
    wb0_valid = 1; wb0_tag = 6'd7; wb0_data = 32'h1;
    wb1_valid = 1; wb1_tag = 6'd7; wb1_data = 32'h2;
    #1;
`ifdef BRU_WB_BYPASS_EN
    chk("sametag_bypass_issue", 64'(issue_valid), 64'd1);
`else
    chk("sametag_c1_hold", 64'(issue_valid), 64'd0);
`endif
    tick(); clear(); #1;
`ifndef BRU_WB_BYPASS_EN
    chk("sametag_c2_issue", 64'(issue_valid), 64'd1);
`endif
    wait_empty(10, "sametag_drain");

    // Reset mid-operation discards a pending entry.
    tick(); clear();
    set_enq(12'h004, 6'd40, 0, 32'h0, 6'd0, 1, 32'h77);
    tick(); clear();
    rst = 1;
    tick(); #1;
    chk("midrst_count", 64'(count), 64'd0);
    rst = 0;
    wb0_valid = 1; wb0_tag = 6'd40; wb0_data = 32'h88;
    tick(); clear(); #1;
    chk("midrst_no_issue", 64'(issue_valid), 64'd0);
    chk("midrst_enq_ready", 64'(enq_ready), 64'd1);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
